// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer and its next-PC calculator.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_RESOLVE = 3'd4
  } fetch_state_e;

  // {A1,A0} as resolved by the controller (A0 = control bit 3, A1 = control bit 4)
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;
  localparam logic [1:0] PCSEL_JR  = 2'b11;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection; every result wraps modulo 2^PC_W.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [1:0]      i_pc_sel,
  input  logic [16:0]     i_imm,
  input  logic [26:0]     i_target,
  input  logic [31:0]     i_rd_value,
  output logic [PC_W-1:0] o_next_pc
);

  logic [31:0] w_seq;
  logic [31:0] w_br;

  // Work at 32 bits so the sign extension is right for any PC_W, then truncate.
  assign w_seq = 32'(i_pc) + 32'd1;
  assign w_br  = w_seq + {{15{i_imm[16]}}, i_imm};

  always_comb begin
    o_next_pc = PC_W'(w_seq);
    case (i_pc_sel)
      PCSEL_BR:  o_next_pc = PC_W'(w_br);
      PCSEL_JMP: o_next_pc = PC_W'({5'd0, i_target});
      PCSEL_JR:  o_next_pc = PC_W'(i_rd_value);
      default:   ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-issue instruction fetch front end: request, capture, issue to decode,
// then wait for the controller's PC-select outcome before the next fetch.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W     = 12,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_instr,
  output logic            instr_valid,
  output logic [31:0]     instr_out,
  output logic [PC_W-1:0] instr_pc,
  input  logic            dec_ready,
  input  logic            resolve_valid,
  input  logic [1:0]      pc_sel,
  input  logic [16:0]     imm,
  input  logic [26:0]     target,
  input  logic [31:0]     rd_value,
  output logic [PC_W-1:0] link_pc,
  output logic            fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, r_link_pc, w_next_pc;
  logic [31:0]     r_instr;
  logic [CNT_W-1:0] r_cnt;
  logic            r_fetch_err;
  logic            w_timeout;

  // Last silent WAIT cycle: the counter hits TIMEOUT on this edge.
  assign w_timeout = (r_state == ST_WAIT) && !imem_valid &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .i_pc       (r_pc),
    .i_pc_sel   (pc_sel),
    .i_imm      (imm),
    .i_target   (target),
    .i_rd_value (rd_value),
    .o_next_pc  (w_next_pc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = ST_FETCH;
      ST_FETCH:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (imem_valid)     w_state_nxt = ST_ISSUE;
        else if (w_timeout) w_state_nxt = ST_FETCH;
      end
      ST_ISSUE:   if (dec_ready)     w_state_nxt = ST_RESOLVE;
      ST_RESOLVE: if (resolve_valid) w_state_nxt = ST_FETCH;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = reset_n && (r_state == ST_FETCH);
    instr_valid = reset_n && (r_state == ST_ISSUE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc        <= PC_W'(RESET_PC);
      r_link_pc   <= '0;
      r_instr     <= '0;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
      case (r_state)
        ST_FETCH: r_cnt <= '0;
        ST_WAIT: begin
          if (imem_valid) r_instr <= imem_instr;
          else            r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_RESOLVE: begin
          if (resolve_valid) begin
            r_link_pc <= r_pc + PC_W'(1);
            r_pc      <= w_next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign instr_pc  = r_pc;
  assign instr_out = r_instr;
  assign link_pc   = r_link_pc;
  assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer plus a standalone check of next_pc_calc.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [11:0] instr_pc;
  logic        dec_ready;
  logic        resolve_valid;
  logic [1:0]  pc_sel;
  logic [16:0] imm;
  logic [26:0] target;
  logic [31:0] rd_value;
  logic [11:0] link_pc;
  logic        fetch_err;

  logic [11:0] np_pc;
  logic [1:0]  np_sel;
  logic [16:0] np_imm;
  logic [26:0] np_tgt;
  logic [31:0] np_rd;
  logic [11:0] np_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(.PC_W(12), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_instr(imem_instr),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .resolve_valid(resolve_valid),
    .pc_sel(pc_sel), .imm(imm), .target(target), .rd_value(rd_value),
    .link_pc(link_pc), .fetch_err(fetch_err)
  );

  next_pc_calc #(.PC_W(12)) u_np (
    .i_pc(np_pc), .i_pc_sel(np_sel), .i_imm(np_imm),
    .i_target(np_tgt), .i_rd_value(np_rd), .o_next_pc(np_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Enter at the FETCH sample point, leave at the next FETCH sample point.
  task automatic run_instr(input logic [11:0] addr, input logic [31:0] ins,
                           input logic [1:0] sel, input logic [16:0] im,
                           input logic [26:0] tg, input logic [31:0] rv,
                           input logic [11:0] exp_link);
    chk("req", imem_req, 1);
    chk("addr", imem_addr, addr);
    step();
    chk("req_once", imem_req, 0);
    imem_valid = 1'b1; imem_instr = ins;
    step();
    imem_valid = 1'b0;
    chk("ivld", instr_valid, 1);
    chk("iout", instr_out, ins);
    chk("ipc", instr_pc, addr);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("ivld_res", instr_valid, 0);
    resolve_valid = 1'b1; pc_sel = sel; imm = im; target = tg; rd_value = rv;
    step();
    resolve_valid = 1'b0; pc_sel = ~sel; imm = ~im; target = ~tg; rd_value = ~rv;
    chk("link", link_pc, exp_link);
  endtask

  typedef struct {
    logic [11:0] pc;
    logic [1:0]  sel;
    logic [16:0] im;
    logic [26:0] tg;
    logic [31:0] rv;
    logic [11:0] exp;
  } np_vec_t;

  np_vec_t np_tab[6];
  logic    ok;
  logic [31:0] held;

  initial begin
    np_tab[0] = '{12'd5,    PCSEL_BR,  17'h1FFFD, 27'd0,         32'd0,          12'd3};
    np_tab[1] = '{12'hFFF,  PCSEL_SEQ, 17'd0,     27'd0,         32'd0,          12'h000};
    np_tab[2] = '{12'hFFE,  PCSEL_BR,  17'h00003, 27'd0,         32'd0,          12'h002};
    np_tab[3] = '{12'd0,    PCSEL_BR,  17'h1FFFF, 27'd0,         32'd0,          12'h000};
    np_tab[4] = '{12'h777,  PCSEL_JMP, 17'd0,     27'h7FF_F456,  32'd0,          12'h456};
    np_tab[5] = '{12'h777,  PCSEL_JR,  17'd0,     27'd0,         32'hDEAD_BEEF,  12'hEEF};
    foreach (np_tab[i]) begin
      np_pc = np_tab[i].pc; np_sel = np_tab[i].sel; np_imm = np_tab[i].im;
      np_tgt = np_tab[i].tg; np_rd = np_tab[i].rv;
      #1;
      chk("np_calc", np_out, np_tab[i].exp);
    end

    reset_n = 1'b0; imem_valid = 1'b0; imem_instr = '0; dec_ready = 1'b0;
    resolve_valid = 1'b0; pc_sel = '0; imm = '0; target = '0; rd_value = '0;
    step(); step();
    chk("rst_req", imem_req, 0);
    chk("rst_ivld", instr_valid, 0);
    chk("rst_iout", instr_out, 0);
    chk("rst_link", link_pc, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_addr", imem_addr, 0);
    reset_n = 1'b1;
    step();

    // sequential, branches, jumps, wrap
    run_instr(12'd0,   32'hA000_0000, PCSEL_SEQ, 17'd0,     27'd0,      32'd0,         12'd1);
    run_instr(12'd1,   32'hA000_0001, PCSEL_SEQ, 17'd0,     27'd0,      32'd0,         12'd2);
    run_instr(12'd2,   32'hA000_0002, PCSEL_SEQ, 17'd0,     27'd0,      32'd0,         12'd3);
    run_instr(12'd3,   32'hA000_0003, PCSEL_SEQ, 17'd0,     27'd0,      32'd0,         12'd4);
    run_instr(12'd4,   32'hA000_0004, PCSEL_SEQ, 17'd0,     27'd0,      32'd0,         12'd5);
    run_instr(12'd5,   32'hB000_0005, PCSEL_BR,  17'h1FFFD, 27'd0,      32'd0,         12'd6);
    run_instr(12'd3,   32'hB000_0003, PCSEL_BR,  17'd10,    27'd0,      32'd0,         12'd4);
    run_instr(12'd14,  32'hC000_000E, PCSEL_JR,  17'd0,     27'd0,      32'd7,         12'd15);
    run_instr(12'd7,   32'hD000_0007, PCSEL_JMP, 17'd0,     27'h0000123, 32'd0,        12'd8);
    run_instr(12'h123, 32'hC000_0123, PCSEL_JR,  17'd0,     27'd0,      32'hFFFF_F0AB, 12'h124);
    run_instr(12'h0AB, 32'hC000_00AB, PCSEL_JR,  17'd0,     27'd0,      32'h0000_0FFF, 12'h0AC);
    run_instr(12'hFFF, 32'hE000_0FFF, PCSEL_SEQ, 17'd0,     27'd0,      32'd0,         12'h000);

    // timeout and retry at pc 0
    chk("to_addr", imem_addr, 0);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (fetch_err !== 1'b0 || imem_req !== 1'b0) ok = 1'b0;
    end
    chk("to_quiet", ok, 1);
    step();
    chk("to_err", fetch_err, 1);
    chk("to_retry_req", imem_req, 1);
    chk("to_retry_addr", imem_addr, 0);
    step();
    chk("to_err_pulse", fetch_err, 0);
    ok = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      if (fetch_err !== 1'b0) ok = 1'b0;
    end
    chk("late14_quiet", ok, 1);
    imem_valid = 1'b1; imem_instr = 32'h1234_5678;
    step();
    imem_valid = 1'b0;
    chk("late14_ivld", instr_valid, 1);
    chk("late14_err", fetch_err, 0);

    // decode stall with a stray resolve in ISSUE
    held = instr_out;
    chk("stall_iout0", held, 32'h1234_5678);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      resolve_valid = (i == 5); pc_sel = PCSEL_JMP; target = 27'h0000555;
      step();
      if (instr_valid !== 1'b1 || instr_out !== held || instr_pc !== 12'd0) ok = 1'b0;
    end
    chk("stall_hold", ok, 1);
    dec_ready = 1'b1; resolve_valid = 1'b1;
    step();
    dec_ready = 1'b0; resolve_valid = 1'b0;
    step();
    chk("res_wait_ivld", instr_valid, 0);
    chk("res_wait_req", imem_req, 0);
    resolve_valid = 1'b1; pc_sel = PCSEL_SEQ;
    step();
    resolve_valid = 1'b0;
    chk("after_stall_req", imem_req, 1);
    chk("after_stall_addr", imem_addr, 1);
    chk("after_stall_link", link_pc, 1);

    // reset while in WAIT
    step();
    reset_n = 1'b0;
    step();
    chk("rw_ivld", instr_valid, 0);
    chk("rw_addr", imem_addr, 0);
    chk("rw_ipc", instr_pc, 0);
    reset_n = 1'b1; imem_valid = 1'b1; imem_instr = 32'hBAD0_BAD0;
    step();
    chk("rw_req", imem_req, 1);
    chk("rw_req_addr", imem_addr, 0);
    imem_valid = 1'b0;
    step(); step();
    chk("rw_late_ign", instr_valid, 0);
    imem_valid = 1'b1; imem_instr = 32'h0F0F_0F0F;
    step();
    imem_valid = 1'b0;
    chk("rw_iout", instr_out, 32'h0F0F_0F0F);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;

    // reset while in RESOLVE
    reset_n = 1'b0;
    step();
    chk("rr_ivld", instr_valid, 0);
    chk("rr_iout", instr_out, 0);
    chk("rr_link", link_pc, 0);
    chk("rr_addr", imem_addr, 0);
    reset_n = 1'b1;
    step();
    chk("rr_req", imem_req, 1);
    chk("rr_req_addr", imem_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
